lcd_pcd8544_rx: RTL
===================

// Module: lcd_pcd8544_rx
// PURPOSE
//  Serial responder for the PCD8544 3-wire LCD bus (sclk/sce/sdc/sdin) driven by the LCD display master.
//  Deserialises bytes in the clk domain, decodes commands, and writes data bytes into an 84x6-byte frame mirror.
//  Used as a bench/loopback display model and as an on-chip snoop so display content can be read back by a host.
// PARAMETERS
//  SYNC_STAGES  2   synchroniser depth for sclk/sce/sdc/sdin (>=2)
//  COLS         84  columns per bank (X range 0..COLS-1)
//  BANKS        6   8-pixel banks (Y range 0..BANKS-1); buffer depth COLS*BANKS = 504
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  synchronous active-low reset
//  sclk       in   1  serial clock, async; data sampled on rising edge
//  sce        in   1  chip enable, active low, async
//  sdc        in   1  0 = command, 1 = data; sampled with bit 0 (8th bit)
//  sdin       in   1  serial data, MSB first
//  rd_addr    in   9  host read address = Y*COLS + X
//  rd_data    out  8  buffer byte at rd_addr, 1-cycle latency
//  byte_vld   out  1  1-cycle pulse per received byte
//  byte_dat   out  8  received byte, valid with byte_vld
//  byte_dc    out  1  sdc of received byte
//  pd,v,h     out  1  function-set bits (power-down, vertical addressing, extended set)
//  disp_de    out  2  display control {D,E}
//  vop        out  7  operating voltage;  bias out 3;  tc out 2
//  cur_x      out  7  current X pointer;  cur_y out 3 current Y pointer
//  frame_done out  1  1-cycle pulse when a data byte is written at address 503
//  cmd_err    out  1  1-cycle pulse on illegal/out-of-range command
// BEHAVIOUR
//  - Reset: byte_vld/byte_dat/byte_dc/frame_done/cmd_err/rd_data=0; pd=1; v=h=0; disp_de=0; vop=0; bias=0; tc=0; cur_x=cur_y=0; bit counter=0. Buffer contents not cleared.
//  - Inputs pass SYNC_STAGES flops; rising edge of synced sclk detected by compare with one extra flop.
//  - On detected rising edge while synced sce=0: shift sdin into LSB, bitcnt++. At bitcnt 7->0 (8th bit): latch byte and sdc; next cycle byte_vld=1.
//  - sce high at any time: bitcnt=0, partial byte discarded, no byte_vld. Edges while sce=1 ignored.
//  - sclk high/low time >= SYNC_STAGES+2 clk cycles required (master runs ~74 clk per half-period).
//  - Decode in byte_vld cycle; register/pointer updates visible the following cycle.
//  - Command (dc=0): 0x00 NOP; 0b001_0_0PVH function set (all modes); H=0: 0b00001D0E display ctrl, 0b01000yyy set Y, 0b1xxxxxxx set X;
//    H=1: 0b000001tt tc, 0b00010bbb bias, 0b1vvvvvvv vop. Y>=BANKS or X>=COLS: no pointer change, cmd_err pulse. Other codes: ignored, cmd_err pulse.
//  - Data (dc=1): buffer[cur_y*COLS+cur_x] <= byte in byte_vld cycle. Accepted regardless of pd.
//  - Auto-increment v=0: x++; x=COLS-1 -> x=0,y++; y=BANKS-1 wraps to 0. v=1: y++; y=BANKS-1 -> y=0,x++; x=COLS-1 wraps to 0.
//  - frame_done pulses with write at (x=83,y=5) in either mode.
//  - Read port: rd_data registered; same-cycle write and read of same address returns old data.
//  - Reset mid-byte: partial byte lost, registers return to reset values on next clk.
// STRUCTURE
//  - lcd_pkg: COLS, BANKS, command opcodes/masks (CMD_FSET, CMD_DCTL, CMD_SETY, CMD_SETX, CMD_TC, CMD_BIAS, CMD_VOP), reset constants.
//  - Sub-module lcd_spi_shift_rx: synchroniser, edge detect, bit counter, byte_vld/byte_dat/byte_dc.
//  - Top: command decoder, mode registers, X/Y pointers, 504x8 inferred single-port-write/registered-read RAM.
// TESTING
//  - Init 0x21,0xC8,0x06,0x13,0x20,0x0C (dc=0) -> vop=0x48, tc=2, bias=3, h=0, pd=0, disp_de=2'b10, no cmd_err.
//  - 0x40|3, 0x80|7 then data 0x7F,0x41 -> cur_y=3, cur_x=9; buffer[259]=0x7F, buffer[260]=0x41.
//  - v=0, 504 data bytes from (0,0) -> one frame_done on last byte, pointers back to (0,0); v=1 (0x22) writes 0xAA at (0,0),(0,1): buffer[0], buffer[84].
//  - Set X=0x80|90 and 0x46 (Y=6) -> cmd_err pulses, cur_x/cur_y unchanged.
//  - sce high after 5 bits, then full byte 0x55 -> exactly one byte_vld, byte_dat=0x55.
//  - Reset asserted mid-frame -> all outputs at reset values, next byte decodes correctly.

Source files
------------

// File: rtl/lcd_pcd8544_rx_pkg.sv
// Shared constants, opcode masks and the command classifier for the PCD8544 receiver.
package lcd_pcd8544_rx_pkg;

  localparam int unsigned Cols  = 84;
  localparam int unsigned Banks = 6;

  localparam logic [7:0] CmdFsetMask = 8'hF8, CmdFset = 8'h20;
  localparam logic [7:0] CmdDctlMask = 8'hFA, CmdDctl = 8'h08;
  localparam logic [7:0] CmdSetyMask = 8'hF8, CmdSety = 8'h40;
  localparam logic [7:0] CmdSetxMask = 8'h80, CmdSetx = 8'h80;
  localparam logic [7:0] CmdTcMask   = 8'hFC, CmdTc   = 8'h04;
  localparam logic [7:0] CmdBiasMask = 8'hF8, CmdBias = 8'h10;
  localparam logic [7:0] CmdVopMask  = 8'h80, CmdVop  = 8'h80;

  localparam logic       PdRst   = 1'b1;
  localparam logic [1:0] DeRst   = 2'b00;
  localparam logic [6:0] VopRst  = 7'd0;
  localparam logic [2:0] BiasRst = 3'd0;
  localparam logic [1:0] TcRst   = 2'd0;

  typedef enum logic [3:0] {
    OpNop, OpFset, OpDctl, OpSety, OpSetx, OpTc, OpBias, OpVop, OpIllegal
  } op_e;

  // Function set and NOP exist in both instruction sets; the rest depend on H.
  function automatic op_e decode_cmd(input logic [7:0] b, input logic h);
    op_e op;
    op = OpIllegal;
    if (b == 8'h00)                             op = OpNop;
    else if ((b & CmdFsetMask) == CmdFset)      op = OpFset;
    else if (!h) begin
      if ((b & CmdSetxMask) == CmdSetx)         op = OpSetx;
      else if ((b & CmdSetyMask) == CmdSety)    op = OpSety;
      else if ((b & CmdDctlMask) == CmdDctl)    op = OpDctl;
    end else begin
      if ((b & CmdVopMask) == CmdVop)           op = OpVop;
      else if ((b & CmdTcMask) == CmdTc)        op = OpTc;
      else if ((b & CmdBiasMask) == CmdBias)    op = OpBias;
    end
    return op;
  endfunction

endpackage

// File: rtl/lcd_pcd8544_rx_if.sv
// PCD8544 3-wire serial bus as seen by the display controller and by this receiver.
interface lcd_pcd8544_rx_if;
  logic sclk;
  logic sce;
  logic sdc;
  logic sdin;

  modport master (output sclk, sce, sdc, sdin);
  modport slave  (input  sclk, sce, sdc, sdin);
endinterface

// File: rtl/lcd_pcd8544_rx_spi_shift.sv
// Synchronises the async serial bus into clk and assembles MSB-first bytes.
module lcd_pcd8544_rx_spi_shift #(
  parameter int unsigned SyncStages = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  lcd_pcd8544_rx_if.slave           bus_if,
  output logic                      byte_vld_o,
  output logic [7:0]                byte_dat_o,
  output logic                      byte_dc_o
);

  logic [SyncStages-1:0] sclk_sync_q, sce_sync_q, sdc_sync_q, sdin_sync_q;
  logic                  sclk_prev_q;
  logic [6:0]            shift_q, shift_d;
  logic [2:0]            bitcnt_q, bitcnt_d;
  logic                  vld_q, vld_d;
  logic [7:0]            dat_q, dat_d;
  logic                  dc_q, dc_d;

  logic sclk_s, sce_s, sdc_s, sdin_s, rise;

  assign sclk_s = sclk_sync_q[SyncStages-1];
  assign sce_s  = sce_sync_q[SyncStages-1];
  assign sdc_s  = sdc_sync_q[SyncStages-1];
  assign sdin_s = sdin_sync_q[SyncStages-1];
  assign rise   = sclk_s & ~sclk_prev_q;

  always_comb begin
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    vld_d    = 1'b0;
    dat_d    = dat_q;
    dc_d     = dc_q;
    if (sce_s) begin
      bitcnt_d = 3'd0;
    end else if (rise) begin
      shift_d  = {shift_q[5:0], sdin_s};
      bitcnt_d = bitcnt_q + 3'd1;
      if (bitcnt_q == 3'd7) begin
        dat_d = {shift_q, sdin_s};
        dc_d  = sdc_s;
        vld_d = 1'b1;
      end
    end
  end

  // Chip enable resets high so a reset never looks like a selected bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      sce_sync_q  <= '1;
      sdc_sync_q  <= '0;
      sdin_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      vld_q       <= 1'b0;
      dat_q       <= '0;
      dc_q        <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SyncStages-2:0], bus_if.sclk};
      sce_sync_q  <= {sce_sync_q[SyncStages-2:0], bus_if.sce};
      sdc_sync_q  <= {sdc_sync_q[SyncStages-2:0], bus_if.sdc};
      sdin_sync_q <= {sdin_sync_q[SyncStages-2:0], bus_if.sdin};
      sclk_prev_q <= sclk_s;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      vld_q       <= vld_d;
      dat_q       <= dat_d;
      dc_q        <= dc_d;
    end
  end

  assign byte_vld_o = vld_q;
  assign byte_dat_o = dat_q;
  assign byte_dc_o  = dc_q;

endmodule

// File: rtl/lcd_pcd8544_rx.sv
// PCD8544 bus responder: decodes commands, tracks X/Y and mirrors display RAM for host readback.
module lcd_pcd8544_rx
  import lcd_pcd8544_rx_pkg::*;
#(
  parameter int unsigned SyncStages = 2,
  parameter int unsigned NumCols    = Cols,
  parameter int unsigned NumBanks   = Banks
) (
  input  logic        clk,
  input  logic        rst_n,
  lcd_pcd8544_rx_if.slave bus_if,
  input  logic [8:0]  rd_addr_i,
  output logic [7:0]  rd_data_o,
  output logic        byte_vld_o,
  output logic [7:0]  byte_dat_o,
  output logic        byte_dc_o,
  output logic        pd_o,
  output logic        v_o,
  output logic        h_o,
  output logic [1:0]  disp_de_o,
  output logic [6:0]  vop_o,
  output logic [2:0]  bias_o,
  output logic [1:0]  tc_o,
  output logic [6:0]  cur_x_o,
  output logic [2:0]  cur_y_o,
  output logic        frame_done_o,
  output logic        cmd_err_o
);

  localparam int unsigned Depth = NumCols * NumBanks;

  logic       byte_vld, byte_dc;
  logic [7:0] byte_dat;

  lcd_pcd8544_rx_spi_shift #(.SyncStages(SyncStages)) u_shift (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_if     (bus_if),
    .byte_vld_o (byte_vld),
    .byte_dat_o (byte_dat),
    .byte_dc_o  (byte_dc)
  );

  logic       pd_q, pd_d, v_q, v_d, h_q, h_d;
  logic [1:0] de_q, de_d, tc_q, tc_d;
  logic [6:0] vop_q, vop_d, x_q, x_d;
  logic [2:0] bias_q, bias_d, y_q, y_d;
  logic       fd_q, fd_d, err_q, err_d;
  logic [7:0] rd_data_q;
  logic [7:0] mem_q [Depth];
  logic [8:0] wr_addr;
  logic       last_x, last_y, we;
  op_e        op;

  assign wr_addr = 9'(y_q) * 9'(NumCols) + 9'(x_q);
  assign last_x  = (x_q == 7'(NumCols - 1));
  assign last_y  = (y_q == 3'(NumBanks - 1));
  assign we      = byte_vld & byte_dc;

  always_comb begin
    pd_d = pd_q;  v_d = v_q;  h_d = h_q;
    de_d = de_q;  tc_d = tc_q;  vop_d = vop_q;  bias_d = bias_q;
    x_d  = x_q;   y_d = y_q;
    fd_d = 1'b0;  err_d = 1'b0;
    op   = decode_cmd(byte_dat, h_q);
    if (byte_vld && byte_dc) begin
      fd_d = last_x & last_y;
      // Horizontal mode walks X first, vertical mode walks Y first.
      if (!v_q) begin
        if (last_x) begin
          x_d = '0;
          y_d = last_y ? '0 : y_q + 3'd1;
        end else begin
          x_d = x_q + 7'd1;
        end
      end else begin
        if (last_y) begin
          y_d = '0;
          x_d = last_x ? '0 : x_q + 7'd1;
        end else begin
          y_d = y_q + 3'd1;
        end
      end
    end else if (byte_vld) begin
      unique case (op)
        OpNop:  ;
        OpFset: begin pd_d = byte_dat[2]; v_d = byte_dat[1]; h_d = byte_dat[0]; end
        OpDctl: de_d = {byte_dat[2], byte_dat[0]};
        OpSety: begin
          if (32'(byte_dat[2:0]) < NumBanks) y_d = byte_dat[2:0];
          else err_d = 1'b1;
        end
        OpSetx: begin
          if (32'(byte_dat[6:0]) < NumCols) x_d = byte_dat[6:0];
          else err_d = 1'b1;
        end
        OpTc:   tc_d   = byte_dat[1:0];
        OpBias: bias_d = byte_dat[2:0];
        OpVop:  vop_d  = byte_dat[6:0];
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pd_q <= PdRst;  v_q <= 1'b0;  h_q <= 1'b0;
      de_q <= DeRst;  tc_q <= TcRst;  vop_q <= VopRst;  bias_q <= BiasRst;
      x_q  <= '0;     y_q <= '0;
      fd_q <= 1'b0;   err_q <= 1'b0;
    end else begin
      pd_q <= pd_d;   v_q <= v_d;   h_q <= h_d;
      de_q <= de_d;   tc_q <= tc_d; vop_q <= vop_d; bias_q <= bias_d;
      x_q  <= x_d;    y_q <= y_d;
      fd_q <= fd_d;   err_q <= err_d;
    end
  end

  // Frame mirror is deliberately not reset; a read racing a write returns the old byte.
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_addr] <= byte_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                       rd_data_q <= '0;
    else if (32'(rd_addr_i) < Depth)  rd_data_q <= mem_q[rd_addr_i];
    else                              rd_data_q <= '0;
  end

  assign rd_data_o    = rd_data_q;
  assign byte_vld_o   = byte_vld;
  assign byte_dat_o   = byte_dat;
  assign byte_dc_o    = byte_dc;
  assign pd_o         = pd_q;
  assign v_o          = v_q;
  assign h_o          = h_q;
  assign disp_de_o    = de_q;
  assign vop_o        = vop_q;
  assign bias_o       = bias_q;
  assign tc_o         = tc_q;
  assign cur_x_o      = x_q;
  assign cur_y_o      = y_q;
  assign frame_done_o = fd_q;
  assign cmd_err_o    = err_q;

endmodule
